pwm_pulse_detect: RTL and testbench

Hardware pulse-width detector for the PWM signal produced by the axi_timer in the embedded system. It is the receiving end of that PWM output and replaces the software pulse-width detection that currently loops the signal back through GPIO. It sits at the top level on sysclk. It measures the high time and low time of each complete PWM period in sysclk cycles and presents latched results, with a strobe, to an axi_gpio input port for the MicroBlaze.

---
 rtl/pwm_pulse_detect.sv | 153 +++++++++++++++
 tb/tb_pwm_pulse_detect.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_pulse_detect.sv
// Measures high and low time of each complete PWM period in sysclk cycles and publishes latched results with a strobe.
// Latency: an input edge is acted on 2 edges after capture; publication on the rise ending a period; no backpressure.
module pwm_pulse_detect #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 sysclk,
    input  logic                 sysreset_n,
    input  logic                 pwm_in,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic [CNT_WIDTH-1:0] low_count,
    output logic [CNT_WIDTH:0]   period_count,
    output logic                 sample_stb,
    output logic                 valid,
    output logic                 stuck_high,
    output logic                 stuck_low
);

    typedef enum logic [1:0] {SYNC_WAIT, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t               state, state_nxt;
    logic                 s1, s2, s3;
    logic                 rise, fall, edge_det, timeout;
    logic [CNT_WIDTH-1:0] hi_cnt, lo_cnt, run_cnt;
    logic                 hi_load, lo_load, publish, flags_clr, to_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign edge_det = rise | fall;
    // An edge in the same cycle as the timeout wins.
    assign timeout  = (run_cnt == TIMEOUT) && !edge_det;

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) state <= SYNC_WAIT;
        else if (clear)  state <= SYNC_WAIT;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hi_load   = 1'b0;
        lo_load   = 1'b0;
        publish   = 1'b0;
        flags_clr = 1'b0;
        to_hit    = 1'b0;
        if (timeout) begin
            state_nxt = SYNC_WAIT;
            to_hit    = 1'b1;
        end else begin
            unique case (state)
                SYNC_WAIT: begin
                    if (rise) begin
                        state_nxt = MEAS_HIGH;
                        hi_load   = 1'b1;
                        flags_clr = 1'b1;
                    end else if (fall) begin
                        flags_clr = 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_nxt = MEAS_LOW;
                        lo_load   = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        state_nxt = MEAS_HIGH;
                        publish   = 1'b1;
                        hi_load   = 1'b1;
                    end
                end
                default: state_nxt = SYNC_WAIT;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            run_cnt      <= '0;
            high_count   <= '0;
            low_count    <= '0;
            period_count <= '0;
            sample_stb   <= 1'b0;
            valid        <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else if (clear) begin
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            run_cnt      <= '0;
            high_count   <= '0;
            low_count    <= '0;
            period_count <= '0;
            sample_stb   <= 1'b0;
            valid        <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else begin
            // Keeps counting past the timeout so the flag fires only once while idle.
            run_cnt <= edge_det ? CNT_ONE : sat_inc(run_cnt);

            if (hi_load)                       hi_cnt <= CNT_ONE;
            else if (state == MEAS_HIGH && s2) hi_cnt <= sat_inc(hi_cnt);

            if (lo_load)                       lo_cnt <= CNT_ONE;
            else if (state == MEAS_LOW && !s2) lo_cnt <= sat_inc(lo_cnt);

            sample_stb <= publish;
            if (publish) begin
                high_count   <= hi_cnt;
                low_count    <= lo_cnt;
                period_count <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
                valid        <= 1'b1;
            end

            if (to_hit) begin
                valid <= 1'b0;
                if (s2) stuck_high <= 1'b1;
                else    stuck_low  <= 1'b1;
            end

            if (flags_clr) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_pulse_detect.sv
// Directed bench for pwm_pulse_detect: synchronous PWM waveforms, timeout, clear and async reset.
module tb_pwm_pulse_detect;

    localparam int CW = 16;

    logic          sysclk;
    logic          sysreset_n;
    logic          pwm_in;
    logic          clear;
    logic [CW-1:0] high_count;
    logic [CW-1:0] low_count;
    logic [CW:0]   period_count;
    logic          sample_stb;
    logic          valid;
    logic          stuck_high;
    logic          stuck_low;

    int vectors     = 0;
    int miscompares = 0;

    pwm_pulse_detect #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(1000)) dut (
        .sysclk      (sysclk),
        .sysreset_n  (sysreset_n),
        .pwm_in      (pwm_in),
        .clear       (clear),
        .high_count  (high_count),
        .low_count   (low_count),
        .period_count(period_count),
        .sample_stb  (sample_stb),
        .valid       (valid),
        .stuck_high  (stuck_high),
        .stuck_low   (stuck_low)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/high"},   64'(high_count),   0);
        chk({tag, "/low"},    64'(low_count),    0);
        chk({tag, "/period"}, 64'(period_count), 0);
        chk({tag, "/stb"},    64'(sample_stb),   0);
        chk({tag, "/valid"},  64'(valid),        0);
        chk({tag, "/sthi"},   64'(stuck_high),   0);
        chk({tag, "/stlo"},   64'(stuck_low),    0);
    endtask

    // One h-high/l-low period; a strobe for the previous period shows up on the 3rd cycle.
    task automatic period(input string tag, input int h, input int l, input int exp_n,
                          input int eh, input int el, input int exp_valid);
        int            n;
        int            pos;
        logic [CW-1:0] ch;
        logic [CW-1:0] cl;
        logic [CW:0]   cp;
        logic          cv;
        n   = 0;
        pos = 0;
        ch  = '0;
        cl  = '0;
        cp  = '0;
        cv  = 1'b0;
        pwm_in = 1'b1;
        for (int i = 1; i <= h + l; i++) begin
            if (i == h + 1) pwm_in = 1'b0;
            tick();
            if (sample_stb) begin
                n++;
                pos = i;
                ch  = high_count;
                cl  = low_count;
                cp  = period_count;
                cv  = valid;
            end
        end
        chk({tag, "/nstb"}, 64'(n), 64'(exp_n));
        if (exp_n == 1) begin
            chk({tag, "/pos"},    64'(pos), 3);
            chk({tag, "/high"},   64'(ch),  64'(eh));
            chk({tag, "/low"},    64'(cl),  64'(el));
            chk({tag, "/period"}, 64'(cp),  64'(eh + el));
            chk({tag, "/svalid"}, 64'(cv),  1);
        end
        chk({tag, "/valid"}, 64'(valid), 64'(exp_valid));
    endtask

    initial begin
        sysreset_n = 1'b0;
        pwm_in     = 1'b0;
        clear      = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        sysreset_n = 1'b1;
        tick();
        tick();

        // 30/70 from reset: first period only arms the measurement
        period("s1p0", 30, 70, 0, 0, 0, 0);
        period("s1p1", 30, 70, 1, 30, 70, 1);
        period("s1p2", 30, 70, 1, 30, 70, 1);

        // switch to 80/20 after a 30-high phase: one transitional 30/20 period
        period("s2p0", 30, 20, 1, 30, 70, 1);
        period("s2p1", 80, 20, 1, 30, 20, 1);
        period("s2p2", 80, 20, 1, 80, 20, 1);
        period("s2p3", 80, 20, 1, 80, 20, 1);

        // stuck high for 1200 cycles; rise acted on at cycle 3, timeout at 1003
        pwm_in = 1'b1;
        for (int t = 1; t <= 1200; t++) begin
            tick();
            if (t == 3) begin
                chk("s3/stb", 64'(sample_stb), 1);
                chk("s3/high_pub", 64'(high_count), 80);
            end
            if (t == 1002) begin
                chk("s3/sthi_early", 64'(stuck_high), 0);
                chk("s3/valid_early", 64'(valid), 1);
            end
            if (t == 1003) begin
                chk("s3/sthi", 64'(stuck_high), 1);
                chk("s3/stlo", 64'(stuck_low), 0);
                chk("s3/valid", 64'(valid), 0);
                chk("s3/high_hold", 64'(high_count), 80);
                chk("s3/low_hold", 64'(low_count), 20);
                chk("s3/period_hold", 64'(period_count), 100);
            end
        end
        pwm_in = 1'b0;
        tick();
        tick();
        chk("s3/sthi_before_fall", 64'(stuck_high), 1);
        tick();
        chk("s3/sthi_after_fall", 64'(stuck_high), 0);
        chk("s3/stlo_after_fall", 64'(stuck_low), 0);
        for (int t = 0; t < 67; t++) tick();
        period("s3p0", 30, 70, 0, 0, 0, 0);
        period("s3p1", 30, 70, 1, 30, 70, 1);

        // 1/3 minimum-width stream
        period("s4p0", 1, 3, 1, 30, 70, 1);
        period("s4p1", 1, 3, 1, 1, 3, 1);
        period("s4p2", 1, 3, 1, 1, 3, 1);
        period("s4p3", 1, 3, 1, 1, 3, 1);

        // clear in the middle of a high phase
        period("s5p0", 30, 70, 1, 1, 3, 1);
        period("s5p1", 30, 70, 1, 30, 70, 1);
        pwm_in = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all_zero("s5clr");
        for (int t = 0; t < 19; t++) tick();
        pwm_in = 1'b0;
        for (int t = 0; t < 70; t++) tick();
        period("s5p2", 30, 70, 0, 0, 0, 0);
        period("s5p3", 30, 70, 1, 30, 70, 1);

        // asynchronous reset mid-period
        pwm_in = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        chk("s6/valid_pre", 64'(valid), 1);
        chk("s6/high_pre", 64'(high_count), 30);
        #3;
        sysreset_n = 1'b0;
        #1;
        chk_all_zero("s6rst");
        tick();
        pwm_in = 1'b0;
        tick();
        tick();
        sysreset_n = 1'b1;
        tick();
        tick();
        period("s6p0", 30, 70, 0, 0, 0, 0);
        period("s6p1", 30, 70, 1, 30, 70, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
